// File: rtl/spi_bridge_pkg.sv
// Shared types and byte constants for the UART-to-SPI command bridge.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ARG,
        EXEC,
        RD_WAIT,
        SEND,
        SEND_WAIT
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_CTRL = 8'h43;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] OP_STAT = 8'h53;

    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    function automatic logic has_args(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_CTRL) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/bridge_timeout_counter.sv
// Inter-byte idle counter: counts while enabled, pulses expired on the
// last allowed cycle and restarts from zero.
module bridge_timeout_counter #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || expired)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/spi_cmd_bridge.sv
// Parses UART command bytes into SPI register accesses and returns
// ack / read-data / error bytes to the UART transmitter.
module spi_cmd_bridge
    import spi_bridge_pkg::*;
#(
    parameter int N              = 7,
    parameter int W              = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i,
    output logic [7:0]   tx_data_o,
    output logic         tx_start_o,
    input  logic         tx_busy_i,
    output logic         wr_o,
    output logic         reg_sel_o,
    output logic [N:0]   addr_o,
    output logic [W-1:0] wdata_o,
    input  logic [31:0]  rdata_i,
    output logic         busy_o,
    output logic         err_o
);

    localparam int AW = N + 1;

    state_t      state, state_n;
    logic [7:0]  op;
    logic [7:0]  arg0;
    logic        arg_cnt;
    logic        rd_cnt;
    logic [1:0]  byte_idx;
    logic [1:0]  rsp_last;
    logic [31:0] rsp_buf;
    logic        busy_seen;
    logic        expired;
    logic        overrun;

    bridge_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (state == GET_ARG),
        .clr     (rx_valid_i || (state != GET_ARG)),
        .expired (expired)
    );

    assign busy_o    = (state != IDLE);
    assign tx_data_o = rsp_buf[7:0];
    assign overrun   = rx_valid_i && (state inside {EXEC, RD_WAIT, SEND, SEND_WAIT});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        wr_o       = 1'b0;
        tx_start_o = 1'b0;
        case (state)
            IDLE:
                if (rx_valid_i) begin
                    if (has_args(rx_data_i))      state_n = GET_ARG;
                    else if (rx_data_i == OP_STAT) state_n = RD_WAIT;
                    else                          state_n = SEND;
                end
            GET_ARG:
                // expiry beats a byte arriving on the same cycle
                if (expired)
                    state_n = IDLE;
                else if (rx_valid_i) begin
                    if (op == OP_RD)  state_n = RD_WAIT;
                    else if (arg_cnt) state_n = EXEC;
                end
            EXEC: begin
                wr_o    = 1'b1;
                state_n = SEND;
            end
            RD_WAIT:
                if (rd_cnt) state_n = SEND;
            SEND:
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    state_n    = SEND_WAIT;
                end
            SEND_WAIT:
                if (busy_seen && !tx_busy_i)
                    state_n = (byte_idx == rsp_last) ? IDLE : SEND;
            default:
                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op        <= '0;
            arg0      <= '0;
            arg_cnt   <= 1'b0;
            rd_cnt    <= 1'b0;
            byte_idx  <= '0;
            rsp_last  <= '0;
            rsp_buf   <= '0;
            busy_seen <= 1'b0;
            reg_sel_o <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            err_o <= overrun || expired ||
                     (state == IDLE && rx_valid_i && !has_args(rx_data_i) && rx_data_i != OP_STAT);
            case (state)
                IDLE: begin
                    arg_cnt   <= 1'b0;
                    rd_cnt    <= 1'b0;
                    byte_idx  <= '0;
                    busy_seen <= 1'b0;
                    if (rx_valid_i) begin
                        op       <= rx_data_i;
                        rsp_last <= (rx_data_i == OP_STAT) ? 2'd3 : 2'd0;
                        if (rx_data_i == OP_STAT)
                            reg_sel_o <= 1'b0;
                        else if (!has_args(rx_data_i))
                            rsp_buf <= {24'h0, RSP_ERR};
                    end
                end
                GET_ARG:
                    if (rx_valid_i && !expired) begin
                        if (op == OP_RD) begin
                            reg_sel_o <= 1'b1;
                            addr_o    <= AW'(rx_data_i);
                        end else if (!arg_cnt) begin
                            arg0    <= rx_data_i;
                            arg_cnt <= 1'b1;
                        end else if (op == OP_WR) begin
                            reg_sel_o <= 1'b1;
                            addr_o    <= AW'(arg0);
                            wdata_o   <= W'(rx_data_i);
                        end else begin
                            reg_sel_o <= 1'b0;
                            wdata_o   <= W'({rx_data_i, arg0});
                        end
                    end
                EXEC:
                    rsp_buf <= {24'h0, RSP_ACK};
                RD_WAIT: begin
                    // second cycle: the registered read mux has settled
                    rd_cnt <= 1'b1;
                    if (rd_cnt)
                        rsp_buf <= (op == OP_STAT) ? rdata_i : {24'h0, rdata_i[7:0]};
                end
                SEND:
                    busy_seen <= 1'b0;
                SEND_WAIT:
                    if (tx_busy_i)
                        busy_seen <= 1'b1;
                    else if (busy_seen && byte_idx != rsp_last) begin
                        byte_idx <= byte_idx + 2'd1;
                        rsp_buf  <= {8'h00, rsp_buf[31:8]};
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed bench for spi_cmd_bridge with a behavioural UART TX busy model.
module tb_spi_cmd_bridge;

    localparam int N  = 7;
    localparam int W  = 16;
    localparam int TO = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   rx_data_i = 8'h00;
    logic         rx_valid_i = 1'b0;
    logic [7:0]   tx_data_o;
    logic         tx_start_o;
    logic         tx_busy_i = 1'b0;
    logic         wr_o;
    logic         reg_sel_o;
    logic [N:0]   addr_o;
    logic [W-1:0] wdata_o;
    logic [31:0]  rdata_i = 32'h0;
    logic         busy_o;
    logic         err_o;

    spi_cmd_bridge #(.N(N), .W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
        .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .rdata_i(rdata_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rx_cyc = 0;

    logic [7:0]   txq[$];
    int           wr_cnt = 0, err_cnt = 0, start_viol = 0, wr_cyc = 0;
    logic         wr_sel;
    logic [N:0]   wr_addr;
    logic [W-1:0] wr_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_o) begin
            wr_cnt   = wr_cnt + 1;
            wr_cyc   = cyc;
            wr_sel   = reg_sel_o;
            wr_addr  = addr_o;
            wr_wdata = wdata_o;
        end
        if (err_o) err_cnt = err_cnt + 1;
        if (tx_start_o && tx_busy_i) start_viol = start_viol + 1;
    end

    // UART TX: busy rises the cycle after a start and stays up 4 cycles
    always begin
        @(negedge clk);
        if (tx_start_o && rst) begin
            txq.push_back(tx_data_o);
            @(posedge clk);
            #1 tx_busy_i = 1'b1;
            repeat (4) @(posedge clk);
            #1 tx_busy_i = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        rx_cyc     = cyc;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic clear_mon();
        txq.delete();
        wr_cnt = 0;
        err_cnt = 0;
        start_viol = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({tx_data_o, tx_start_o, wr_o, reg_sel_o, addr_o, wdata_o, busy_o, err_o} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0",
                {tx_data_o, tx_start_o, wr_o, reg_sel_o, addr_o, wdata_o, busy_o, err_o});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_idle: busy %b want 0", busy_o); end
    endtask

    task automatic test_write();
        bit ok;
        clear_mon();
        send_byte(8'h57); send_byte(8'h05); send_byte(8'hA3);
        wait_idle(ok);
        checks++; if (!ok) begin fails++; $display("FAIL wr_done: timed out waiting for idle"); end
        checks++; if (wr_cnt !== 1) begin fails++; $display("FAIL wr_count: got %0d want 1", wr_cnt); end
        checks++; if ({wr_sel, wr_addr, wr_wdata} !== {1'b1, 8'h05, 16'h00A3}) begin
            fails++; $display("FAIL wr_fields: sel %b addr %h wdata %h want 1 05 00a3", wr_sel, wr_addr, wr_wdata);
        end
        checks++; if (wr_cyc !== rx_cyc + 1) begin
            fails++; $display("FAIL wr_latency: wr at %0d want %0d", wr_cyc, rx_cyc + 1);
        end
        checks++; if (txq.size() !== 1 || txq[0] !== 8'h4B) begin
            fails++; $display("FAIL wr_ack: %0d bytes first %h want 1 byte 4b", txq.size(), txq.size() ? txq[0] : 8'h00);
        end
    endtask

    task automatic test_ctrl();
        bit ok;
        clear_mon();
        send_byte(8'h43); send_byte(8'h34); send_byte(8'h12);
        wait_idle(ok);
        checks++; if (!ok || wr_cnt !== 1) begin fails++; $display("FAIL ctrl_count: ok %b wr %0d want 1", ok, wr_cnt); end
        checks++; if ({wr_sel, wr_wdata} !== {1'b0, 16'h1234}) begin
            fails++; $display("FAIL ctrl_fields: sel %b wdata %h want 0 1234", wr_sel, wr_wdata);
        end
        checks++; if (txq.size() !== 1 || txq[0] !== 8'h4B) begin
            fails++; $display("FAIL ctrl_ack: %0d bytes want 1 byte 4b", txq.size());
        end
    endtask

    task automatic test_stat();
        bit ok;
        logic [31:0] got;
        clear_mon();
        rdata_i = 32'hDEADBEEF;
        send_byte(8'h53);
        wait_idle(ok);
        got = 32'h0;
        for (int i = 0; i < txq.size() && i < 4; i++) got[8*i +: 8] = txq[i];
        checks++; if (!ok || txq.size() !== 4) begin fails++; $display("FAIL stat_len: ok %b bytes %0d want 4", ok, txq.size()); end
        checks++; if (got !== 32'hDEADBEEF) begin fails++; $display("FAIL stat_bytes: got %h want deadbeef (LSB first)", got); end
        checks++; if (start_viol !== 0 || wr_cnt !== 0 || reg_sel_o !== 1'b0) begin
            fails++; $display("FAIL stat_side: viol %0d wr %0d sel %b want 0 0 0", start_viol, wr_cnt, reg_sel_o);
        end
    endtask

    task automatic test_read();
        bit ok;
        clear_mon();
        rdata_i = 32'h1234563C;
        send_byte(8'h52); send_byte(8'h05);
        wait_idle(ok);
        checks++; if (!ok || txq.size() !== 1 || txq[0] !== 8'h3C) begin
            fails++; $display("FAIL rd_byte: ok %b bytes %0d first %h want 3c", ok, txq.size(), txq.size() ? txq[0] : 8'h00);
        end
        checks++; if ({reg_sel_o, addr_o} !== {1'b1, 8'h05} || wr_cnt !== 0) begin
            fails++; $display("FAIL rd_sel: sel %b addr %h wr %0d want 1 05 0", reg_sel_o, addr_o, wr_cnt);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        clear_mon();
        rdata_i = 32'h000000A5;
        send_byte(8'h52); send_byte(8'h06); send_byte(8'h99);
        wait_idle(ok);
        checks++; if (err_cnt !== 1) begin fails++; $display("FAIL ovr_err: %0d pulses want 1", err_cnt); end
        checks++; if (!ok || txq.size() !== 1 || txq[0] !== 8'hA5) begin
            fails++; $display("FAIL ovr_rsp: bytes %0d want 1 byte a5", txq.size());
        end
    endtask

    task automatic test_error();
        bit ok;
        clear_mon();
        send_byte(8'h77);
        wait_idle(ok);
        checks++; if (err_cnt !== 1 || txq.size() !== 1 || txq[0] !== 8'h3F) begin
            fails++; $display("FAIL bad_op: err %0d bytes %0d want 1 err, 1 byte 3f", err_cnt, txq.size());
        end
        clear_mon();
        send_byte(8'h57);
        repeat (TO - 2) @(negedge clk);
        checks++; if (busy_o !== 1'b1 || err_cnt !== 0) begin
            fails++; $display("FAIL to_early: busy %b err %0d want 1 0", busy_o, err_cnt);
        end
        repeat (2) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b1) begin
            fails++; $display("FAIL to_expire: busy %b err %b want 0 1", busy_o, err_o);
        end
        repeat (20) @(negedge clk);
        checks++; if (wr_cnt !== 0 || txq.size() !== 0 || err_cnt !== 1) begin
            fails++; $display("FAIL to_quiet: wr %0d tx %0d err %0d want 0 0 1", wr_cnt, txq.size(), err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        send_byte(8'h57); send_byte(8'h05);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({busy_o, reg_sel_o, addr_o, wdata_o, tx_data_o} !== '0) begin
            fails++; $display("FAIL mid_reset: busy %b sel %b addr %h wdata %h tx %h want all 0",
                busy_o, reg_sel_o, addr_o, wdata_o, tx_data_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_byte(8'h57); send_byte(8'h0A); send_byte(8'h5C);
        wait_idle(ok);
        checks++; if (!ok || wr_cnt !== 1 || {wr_sel, wr_addr, wr_wdata} !== {1'b1, 8'h0A, 16'h005C}) begin
            fails++; $display("FAIL mid_after: wr %0d sel %b addr %h wdata %h want 1 1 0a 005c",
                wr_cnt, wr_sel, wr_addr, wr_wdata);
        end
        checks++; if (txq.size() !== 1 || txq[0] !== 8'h4B) begin
            fails++; $display("FAIL mid_tx: %0d bytes want 1 byte 4b", txq.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_ctrl();
        test_stat();
        test_read();
        test_overrun();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_bridge.md
Name: spi_cmd_bridge

Overview:
Command parser that sits directly upstream of the SPI interface top. It consumes bytes from the UART receiver and turns them into the register-access signals the SPI interface expects: the write pulse, the register select, the address and the write data. For reads and acknowledgements it returns response bytes to the UART transmitter. It replaces the switch/button path so that a host can drive the SPI peripheral over the serial link.

Parameters:
N, 7, address MSB index; the address is N+1 bits wide.
W, 16, width of the control-register write data.
TIMEOUT_CYCLES, 100000, maximum number of idle clk cycles allowed between bytes of one command.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data_i  in  8  received byte from UART RX
rx_valid_i  in  1  one-cycle strobe: rx_data_i is valid
tx_data_o  out  8  byte to send to UART TX
tx_start_o  out  1  one-cycle strobe: start transmitting tx_data_o
tx_busy_i  in  1  UART TX busy; goes high the cycle after tx_start_o and stays high until the byte is sent
wr_o  out  1  one-cycle write pulse to the SPI interface
reg_sel_o  out  1  register select: 1 = data register, 0 = control register
addr_o  out  N+1  data-register address
wdata_o  out  W  write data; data-register writes use bits [7:0], upper bits 0
rdata_i  in  32  SPI interface read mux output (data or control, chosen by reg_sel_o)
busy_o  out  1  high whenever the FSM is not in IDLE
err_o  out  1  one-cycle pulse on a timeout, an unknown opcode, or an overrun

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. All outputs are 0; tx_data_o = 0x00. The argument buffer and the timeout counter are cleared. A reset in the middle of a command discards it and sends no response.
- Opcodes (first byte of a command):
  - 0x57 'W': 2 argument bytes, addr then data.
  - 0x43 'C': 2 argument bytes, ctrl[7:0] then ctrl[15:8].
  - 0x52 'R': 1 argument byte, addr.
  - 0x53 'S': no arguments.
  - Any other value: unknown opcode.
- FSM states: IDLE, GET_ARG, EXEC, RD_WAIT, SEND, SEND_WAIT.
- IDLE:
  - Known opcode with arguments: latch the opcode and go to GET_ARG.
  - 'S': go to RD_WAIT with reg_sel_o=0.
  - Unknown opcode: pulse err_o, load response 0x3F, go to SEND.
- GET_ARG:
  - Each rx_valid_i stores one byte and resets the timeout counter.
  - After the last argument byte: go to EXEC for 'W'/'C', or to RD_WAIT for 'R'.
- EXEC, one cycle:
  - wr_o=1.
  - 'W': reg_sel_o=1, addr_o=addr, wdata_o={0,data}.
  - 'C': reg_sel_o=0, wdata_o=ctrl.
  - Load response 0x4B 'K', go to SEND.
  - Latency: wr_o is asserted exactly 1 cycle after the rx_valid_i of the last argument byte.
- RD_WAIT:
  - reg_sel_o and addr_o are driven for 2 cycles to cover the registered read path, then rdata_i is sampled.
  - 'R' responds with 1 byte, rdata_i[7:0].
  - 'S' responds with 4 bytes of rdata_i, LSB first.
- SEND:
  - When tx_busy_i=0: drive tx_data_o and pulse tx_start_o for one cycle, then go to SEND_WAIT.
- SEND_WAIT:
  - Wait for tx_busy_i to rise and then fall.
  - Then either send the next byte (back to SEND) or go to IDLE.
- reg_sel_o and addr_o hold their last values between commands; only wr_o is a pulse.
- Timeout: in GET_ARG the counter increments every cycle without rx_valid_i. When it reaches TIMEOUT_CYCLES-1, pulse err_o and go to IDLE with no response.
- Overrun: rx_valid_i in EXEC, RD_WAIT, SEND or SEND_WAIT drops the byte and pulses err_o. The current command is not disturbed.
- rx_valid_i on the same cycle as a timeout expiry: the timeout wins and the byte is dropped.
- The byte counter for the 4-byte 'S' response is 2 bits and stops at 3; it does not wrap.

Decomposition:
- Package spi_bridge_pkg:
  - state enum.
  - Opcode constants OP_WR=8'h57, OP_CTRL=8'h43, OP_RD=8'h52, OP_STAT=8'h53.
  - Response constants RSP_ACK=8'h4B, RSP_ERR=8'h3F.
- One sub-module, bridge_timeout_counter: a counter with clear and an expiry pulse.

Test Plan:
- Send 57 05 A3 -> one wr_o pulse with reg_sel_o=1, addr_o=0x05, wdata_o=0x00A3, 1 cycle after the byte A3; then tx byte 0x4B.
- Send 43 34 12 -> wr_o pulse with reg_sel_o=0, wdata_o=0x1234; then tx 0x4B.
- With rdata_i=0xDEADBEEF, send 53 -> tx bytes EF, BE, AD, DE in order, each waiting for tx_busy_i to rise and fall.
- Send 52 05 with rdata_i[7:0]=0x3C -> addr_o=0x05, reg_sel_o=1, tx 0x3C, no wr_o pulse.
- Send 77 -> err_o pulse and tx 0x3F; then send 57 and stall TIMEOUT_CYCLES -> err_o pulse, back in IDLE, no wr_o, no tx.
- Assert rst low in the middle of a 'W' (after the addr byte) -> all outputs 0 immediately; a following complete 'W' command executes normally.
